// File: rtl/wshb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wshb_pkg
// Description : Shared types and constants for the Wishbone bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package wshb_pkg;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    // One-hot grant vector {m1, m0} for a given arbiter state.
    function automatic logic [1:0] gnt_vec(input arb_state_t st);
        return {st == GNT1, st == GNT0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_next_gnt.sv
`default_nettype none
// ============================================================================
// Module      : arb_next_gnt
// Description : Next-grant decision for the two-master Wishbone arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_next_gnt
    import wshb_pkg::*;
#(
    parameter int M0_PRIORITY = 1
) (
    input  arb_state_t state,
    input  logic       m0_cyc,
    input  logic       m1_cyc,
    input  logic       last_gnt,
    output arb_state_t next_state,
    output logic       next_last_gnt
);

    always_comb begin
        next_state    = state;
        next_last_gnt = last_gnt;
        case (state)
            IDLE: begin
                // On contention, round-robin favours whoever was not served last.
                if (m0_cyc && m1_cyc)
                    next_state = ((M0_PRIORITY != 0) || last_gnt) ? GNT0 : GNT1;
                else if (m0_cyc)
                    next_state = GNT0;
                else if (m1_cyc)
                    next_state = GNT1;
                else
                    next_state = IDLE;
            end
            GNT0: begin
                if (!m0_cyc) begin
                    next_last_gnt = 1'b0;
                    next_state    = m1_cyc ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc) begin
                    next_last_gnt = 1'b1;
                    next_state    = m0_cyc ? GNT0 : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wshb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wshb_arbiter
// Description : Two-master / one-slave Wishbone classic arbiter, whole-cycle grants.
// Revision    : 1.0 - initial release
// ============================================================================
module wshb_arbiter
    import wshb_pkg::*;
#(
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int M0_PRIORITY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_cyc,
    input  logic                m0_stb,
    input  logic                m0_we,
    input  logic [ADDR_W-1:0]   m0_adr,
    input  logic [DATA_W-1:0]   m0_dat_ms,
    input  logic [DATA_W/8-1:0] m0_sel,
    output logic                m0_ack,
    output logic [DATA_W-1:0]   m0_dat_sm,
    input  logic                m1_cyc,
    input  logic                m1_stb,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_adr,
    input  logic [DATA_W-1:0]   m1_dat_ms,
    input  logic [DATA_W/8-1:0] m1_sel,
    output logic                m1_ack,
    output logic [DATA_W-1:0]   m1_dat_sm,
    output logic                s_cyc,
    output logic                s_stb,
    output logic                s_we,
    output logic [ADDR_W-1:0]   s_adr,
    output logic [DATA_W-1:0]   s_dat_ms,
    output logic [DATA_W/8-1:0] s_sel,
    input  logic                s_ack,
    input  logic [DATA_W-1:0]   s_dat_sm,
    output logic [1:0]          gnt
);

    arb_state_t r_state;
    arb_state_t w_next_state;
    logic       r_last_gnt;
    logic       w_next_last_gnt;
    logic [1:0] r_gnt;

    arb_next_gnt #(
        .M0_PRIORITY (M0_PRIORITY)
    ) u_next_gnt (
        .state         (r_state),
        .m0_cyc        (m0_cyc),
        .m1_cyc        (m1_cyc),
        .last_gnt      (r_last_gnt),
        .next_state    (w_next_state),
        .next_last_gnt (w_next_last_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_last_gnt <= 1'b1;
            r_gnt      <= 2'b00;
        end else begin
            r_state    <= w_next_state;
            r_last_gnt <= w_next_last_gnt;
            r_gnt      <= gnt_vec(w_next_state);
        end
    end

    assign gnt = r_gnt;

    // Pass-through is combinational, so an owner dropping cyc is seen by the slave at once.
    always_comb begin
        s_cyc     = 1'b0;
        s_stb     = 1'b0;
        s_we      = 1'b0;
        s_adr     = '0;
        s_dat_ms  = '0;
        s_sel     = '0;
        m0_ack    = 1'b0;
        m0_dat_sm = '0;
        m1_ack    = 1'b0;
        m1_dat_sm = '0;
        case (r_state)
            GNT0: begin
                s_cyc     = m0_cyc;
                s_stb     = m0_stb;
                s_we      = m0_we;
                s_adr     = m0_adr;
                s_dat_ms  = m0_dat_ms;
                s_sel     = m0_sel;
                m0_ack    = s_ack;
                m0_dat_sm = s_dat_sm;
            end
            GNT1: begin
                s_cyc     = m1_cyc;
                s_stb     = m1_stb;
                s_we      = m1_we;
                s_adr     = m1_adr;
                s_dat_ms  = m1_dat_ms;
                s_sel     = m1_sel;
                m1_ack    = s_ack;
                m1_dat_sm = s_dat_sm;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/wshb_arbiter.md
Name: wshb_arbiter

Overview:
- Two-master, one-slave Wishbone classic arbiter.
- Shares the SDRAM framebuffer slave between two masters:
  - m0: the video fetch master, which fills the VGA pixel FIFO.
  - m1: the pattern/mire writer.
- Sits in Top between the two masters and the SDRAM controller port.
- Grants whole bus cycles (CYC envelopes) and never preempts an owner. Arbitration is fixed-priority or round-robin.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; SEL width is DATA_W/8.
- M0_PRIORITY, 1, 1 = m0 (video) always wins contention; 0 = round-robin on contention.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 cycle/strobe/write.
- m0_adr  in  ADDR_W  master 0 address.
- m0_dat_ms  in  DATA_W  master 0 write data.
- m0_sel  in  DATA_W/8  master 0 byte enables.
- m0_ack  out  1  ack to master 0.
- m0_dat_sm  out  DATA_W  read data to master 0.
- m1_*  same set as m0_*, for master 1.
- s_cyc, s_stb, s_we  out  1 each  to slave.
- s_adr  out  ADDR_W  to slave.
- s_dat_ms  out  DATA_W  to slave.
- s_sel  out  DATA_W/8  to slave.
- s_ack  in  1  slave ack.
- s_dat_sm  in  DATA_W  slave read data.
- gnt  out  2  one-hot current grant {m1,m0}; 00 = idle. For LEDs/debug.

Behaviour:
- Reset and initial state:
  - State register: IDLE, GNT0, GNT1 (registered, one-hot or encoded).
  - Register last_gnt (1 bit) records the master most recently served; reset value 1, so m0 wins the first round-robin contention.
  - Reset values: state=IDLE, last_gnt=1, gnt=00.
  - In IDLE: s_cyc=s_stb=s_we=0, s_adr=0, s_dat_ms=0, s_sel=0, m0_ack=m1_ack=0, m0_dat_sm=m1_dat_sm=0.
- Output muxing (combinational from the state register):
  - GNTx: all s_* outputs = mx_* inputs; mx_ack = s_ack; mx_dat_sm = s_dat_sm.
  - The non-granted master always sees ack=0 and dat_sm=0.
  - IDLE: all slave controls are 0.
- Grant latency: a request (mx_cyc=1) sampled at edge n from IDLE gives state GNTx after edge n, so the slave sees mx_cyc from cycle n+1. Minimum latency 1 cycle.
- IDLE transitions:
  - Only m0_cyc → GNT0.
  - Only m1_cyc → GNT1.
  - Both, M0_PRIORITY=1 → GNT0.
  - Both, M0_PRIORITY=0 → the master ≠ last_gnt.
  - Neither → stay IDLE.
- GNTx transitions:
  - Stay while mx_cyc=1. No timeout, no preemption.
  - When mx_cyc=0 is sampled: if the other master's cyc=1, go directly to its grant state (no idle gap); otherwise go to IDLE.
  - last_gnt<=x on every GNTx exit.
  - During the cycle the owner drops cyc, s_cyc is already 0 (combinational pass-through), so no spurious slave cycle occurs.
- Simultaneous events:
  - Owner releases while the other requests: direct handover in one edge.
  - With M0_PRIORITY=0 and both masters re-requesting continuously, grants strictly alternate.
  - With M0_PRIORITY=1: handover GNT0→GNT1 happens whenever m0_cyc=0 and m1_cyc=1, but GNT1→GNT0 waits for m1 to release. No preemption in either mode.
- Stray ack: s_ack while IDLE is ignored; both acks stay 0.
- Reset mid-transfer: rst=1 forces IDLE at the next edge regardless of cyc/ack. Outputs return to reset values, and masters must restart their cycles. No state is carried across reset.
- gnt = {state==GNT1, state==GNT0}, registered (same timing as state).

Decomposition:
- Shared package wshb_pkg:
  - typedef arb_state_t enum {IDLE, GNT0, GNT1}.
  - Constants DEFAULT_ADDR_W=32, DEFAULT_DATA_W=32.
- Natural sub-module: arb_next_gnt. Pure next-state/grant decision from {state, m0_cyc, m1_cyc, last_gnt, M0_PRIORITY}, reusable for a future 3-master version. The mux stays in the top module.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 3 cycles with m0_cyc=m1_cyc=1.
  - Response: gnt=00, s_cyc=0 and both acks 0 throughout. After rst drops, gnt=01 one cycle later (M0_PRIORITY=1).
- Single master m1:
  - Stimulus: m1_cyc=m1_stb=1, we=1, adr=0x100, dat=0xCAFEF00D; slave acks after 2 cycles.
  - Response: s_adr=0x100, s_dat_ms=0xCAFEF00D; m1_ack pulses exactly on the s_ack cycle; m0_ack stays 0.
- Direct handover:
  - Stimulus: m0 holds cyc for a 4-beat burst while m1_cyc=1 waits.
  - Response: m1 is never forwarded during the burst. m0_cyc falls at cycle n → gnt=10 from cycle n+1, with no IDLE cycle between.
- Round-robin (M0_PRIORITY=0):
  - Stimulus: both masters issue back-to-back single-beat cycles for 8 grants.
  - Response: gnt sequence 01,10,01,10,… and each master receives exactly 4 acks.
- Fixed priority (M0_PRIORITY=1):
  - Stimulus: both request from IDLE.
  - Response: gnt=01. After m0 releases, gnt=10. m0 re-requesting during GNT1 waits until m1_cyc=0.
- Reset mid-transfer:
  - Stimulus: rst=1 asserted while GNT1 with s_stb=1 and no ack yet.
  - Response: next cycle s_cyc=0, gnt=00, m1_ack=0. With m0_cyc=1 afterwards, m0 is granted first (last_gnt reset to 1).
